// File: rtl/uart_pkt_defs.sv
// Shared definitions for the UART packet receive controller: FSM states,
// error codes and the default frame start marker.
package uart_pkt_defs;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_DRAIN
  } pkt_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts armed cycles since the last kick and pulses
// expire once when the allowed gap has run out.
module uart_gap_timer #(
  parameter int unsigned TO_CYC = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic kick,
  output logic expire
);

  localparam int unsigned CW = (TO_CYC > 1) ? $clog2(TO_CYC + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TO_CYC - 2);

  logic [CW-1:0] cnt;

  // Fires as the count steps to TO_CYC-1, so the registered error lands
  // TO_CYC cycles after the last kick. A kick in the same cycle wins.
  assign expire = arm && !kick && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!arm || kick || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_pkt_rx_ctrl.sv
// Packet-level receive controller behind a byte UART: sync hunt, length /
// payload / checksum sequencing, inter-byte timeout, valid/ready drain.
module uart_pkt_rx_ctrl
  import uart_pkt_defs::*;
#(
  parameter int unsigned CLK_FREQ      = 50000000,
  parameter int unsigned BAUD_RATE     = 9600,
  parameter logic [7:0]  SYNC_BYTE     = DEFAULT_SYNC_BYTE,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [1:0] err_code,
  output logic       overrun
);

  localparam int unsigned TO_CYC    = TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUD_RATE);
  localparam int unsigned AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  // Downstream handshake: a byte moves when out_valid && out_ready at a rising
  // clk edge; while out_valid && !out_ready, out_data/out_valid/out_last hold.
  pkt_state_t state, state_n;
  logic [7:0] len, chk, wr_ptr, rd_ptr;
  logic [7:0] pbuf [MAX_LEN];
  logic       arm, expire, xfer;
  logic       load_len, buf_we, ok_n, err_n, ovr_n;
  logic [1:0] code_n;

  assign arm       = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHK);
  assign out_valid = (state == ST_DRAIN);
  assign out_data  = out_valid ? pbuf[rd_ptr[AW-1:0]] : 8'h00;
  assign out_last  = out_valid && (rd_ptr == len - 8'd1);
  assign xfer      = out_valid && out_ready;

  uart_gap_timer #(.TO_CYC(TO_CYC)) u_gap_timer (
    .clk   (clk),
    .rst   (rst),
    .arm   (arm),
    .kick  (rx_done),
    .expire(expire)
  );

  always_comb begin
    state_n  = state;
    ok_n     = 1'b0;
    err_n    = 1'b0;
    code_n   = err_code;
    ovr_n    = 1'b0;
    load_len = 1'b0;
    buf_we   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (rx_done && enable && (rx_data == SYNC_BYTE)) state_n = ST_LEN;
      end
      ST_LEN, ST_PAYLOAD, ST_CHK: begin
        if (!enable) begin
          state_n = ST_IDLE;
        end else if (rx_done) begin
          if (state == ST_LEN) begin
            if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
              err_n   = 1'b1;
              code_n  = ERR_LEN;
              state_n = ST_IDLE;
            end else begin
              load_len = 1'b1;
              state_n  = ST_PAYLOAD;
            end
          end else if (state == ST_PAYLOAD) begin
            buf_we = 1'b1;
            if (wr_ptr + 8'd1 == len) state_n = ST_CHK;
          end else if (rx_data == chk) begin
            ok_n    = 1'b1;
            state_n = ST_DRAIN;
          end else begin
            err_n   = 1'b1;
            code_n  = ERR_CHK;
            state_n = ST_IDLE;
          end
        end else if (expire) begin
          err_n   = 1'b1;
          code_n  = ERR_TIMEOUT;
          state_n = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        ovr_n = rx_done;
        if (xfer && out_last) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      len      <= '0;
      chk      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_ok   <= 1'b0;
      pkt_err  <= 1'b0;
      err_code <= ERR_NONE;
      overrun  <= 1'b0;
    end else begin
      state    <= state_n;
      pkt_ok   <= ok_n;
      pkt_err  <= err_n;
      err_code <= code_n;
      overrun  <= ovr_n;
      if (load_len) begin
        len    <= rx_data;
        chk    <= rx_data;
        wr_ptr <= '0;
      end else if (buf_we) begin
        chk    <= chk ^ rx_data;
        wr_ptr <= wr_ptr + 8'd1;
      end
      if (state != ST_DRAIN) rd_ptr <= '0;
      else if (xfer)         rd_ptr <= rd_ptr + 8'd1;
    end
  end

  // Payload storage has no reset; it is only read after being fully written.
  always_ff @(posedge clk) begin
    if (buf_we) pbuf[wr_ptr[AW-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_uart_pkt_rx_ctrl.sv
// Bench for uart_pkt_rx_ctrl: directed frames plus random streams checked
// against a frame-level parser model of the byte stream.
module tb_uart_pkt_rx_ctrl;

  localparam int unsigned CLK_FREQ      = 100;
  localparam int unsigned BAUD_RATE     = 10;
  localparam int unsigned MAX_LEN       = 16;
  localparam int unsigned TIMEOUT_BYTES = 2;
  localparam int TO_CYC = TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUD_RATE);
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst, enable, rx_done, out_ready;
  logic [7:0] rx_data;
  logic [7:0] out_data;
  logic       out_valid, out_last, pkt_ok, pkt_err, overrun;
  logic [1:0] err_code;

  uart_pkt_rx_ctrl #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .SYNC_BYTE(SYNC),
    .MAX_LEN(MAX_LEN), .TIMEOUT_BYTES(TIMEOUT_BYTES)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .rx_data(rx_data), .rx_done(rx_done),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .pkt_ok(pkt_ok), .pkt_err(pkt_err), .err_code(err_code), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [8:0] exp_q[$];
  logic [1:0] exp_err_q[$];
  logic [1:0] got_err_q[$];
  logic [7:0] stim_q[$];
  int         gap_q[$];
  int         xfer_cyc[$];
  int         exp_ok = 0, got_ok = 0, exp_ovr = 0, got_ovr = 0;
  logic       prev_hold = 1'b0, prev_last = 1'b0;
  logic [8:0] prev_out = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // One clock: sample this cycle's outputs, then advance past the next edge.
  task automatic step();
    if (prev_hold) begin
      check("hold_valid", 32'(out_valid), 32'(1'b1));
      check("hold_data", 32'({out_last, out_data}), 32'(prev_out));
    end
    if (prev_last) check("valid_after_last", 32'(out_valid), 32'(1'b0));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("out_extra", 32'({out_last, out_data}), 32'h200);
      else check("out_byte", 32'({out_last, out_data}), 32'(exp_q.pop_front()));
      xfer_cyc.push_back(cyc);
    end
    prev_hold = out_valid && !out_ready;
    prev_last = out_valid && out_ready && out_last;
    prev_out  = {out_last, out_data};
    if (pkt_ok)  got_ok++;
    if (pkt_err) got_err_q.push_back(err_code);
    if (overrun) got_ovr++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic add_byte(input logic [7:0] b, input int gap);
    stim_q.push_back(b);
    gap_q.push_back(gap);
  endtask

  task automatic add_frame(input int len, input bit bad);
    logic [7:0] x, p;
    add_byte(SYNC, $urandom_range(0, 4));
    add_byte(8'(len), $urandom_range(0, 4));
    x = 8'(len);
    for (int k = 0; k < len; k++) begin
      p = 8'($urandom);
      x ^= p;
      add_byte(p, $urandom_range(0, 4));
    end
    if (bad) x ^= 8'($urandom_range(1, 255));
    add_byte(x, MAX_LEN + 4);
  endtask

  // Frame parser over the whole stimulus stream.
  task automatic model_stream();
    int i, n, len;
    logic [7:0] x;
    i = 0;
    n = stim_q.size();
    while (i < n) begin
      if (stim_q[i] != SYNC) begin
        i++;
      end else if (i + 1 >= n) begin
        i = n;
      end else begin
        len = int'(stim_q[i+1]);
        if (len == 0 || len > int'(MAX_LEN)) begin
          exp_err_q.push_back(2'd1);
          i += 2;
        end else if (i + 2 + len >= n) begin
          i = n;
        end else begin
          x = 8'(len);
          for (int k = 0; k < len; k++) x ^= stim_q[i+2+k];
          if (stim_q[i+2+len] == x) begin
            exp_ok++;
            for (int k = 0; k < len; k++) exp_q.push_back({k == len - 1, stim_q[i+2+k]});
          end else begin
            exp_err_q.push_back(2'd2);
          end
          i += len + 3;
        end
      end
    end
  endtask

  task automatic run_stream();
    for (int i = 0; i < stim_q.size(); i++) begin
      send_byte(stim_q[i]);
      idle(gap_q[i]);
    end
  endtask

  task automatic scenario_end(input string tag);
    check({tag, "_ok_count"}, 32'(got_ok), 32'(exp_ok));
    check({tag, "_err_count"}, 32'(got_err_q.size()), 32'(exp_err_q.size()));
    for (int i = 0; i < exp_err_q.size() && i < got_err_q.size(); i++)
      check({tag, "_err_code"}, 32'(got_err_q[i]), 32'(exp_err_q[i]));
    check({tag, "_bytes_missing"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_overrun_count"}, 32'(got_ovr), 32'(exp_ovr));
    exp_q.delete(); exp_err_q.delete(); got_err_q.delete();
    stim_q.delete(); gap_q.delete(); xfer_cyc.delete();
    exp_ok = 0; got_ok = 0; exp_ovr = 0; got_ovr = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_pkt_ok"}, 32'(pkt_ok), 32'd0);
    check({tag, "_pkt_err"}, 32'(pkt_err), 32'd0);
    check({tag, "_err_code"}, 32'(err_code), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    int k;
    rst = 1'b1; enable = 1'b1; rx_done = 1'b0; rx_data = 8'h00; out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // good 3-byte frame
    add_byte(SYNC, 1); add_byte(8'h03, 1); add_byte(8'h11, 1);
    add_byte(8'h22, 1); add_byte(8'h33, 1); add_byte(8'h03, 24);
    model_stream();
    run_stream();
    check("good_xfers", 32'(xfer_cyc.size()), 32'd3);
    if (xfer_cyc.size() == 3) begin
      check("good_consec_1", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd1);
      check("good_consec_2", 32'(xfer_cyc[2] - xfer_cyc[1]), 32'd1);
    end
    check("good_err_code", 32'(err_code), 32'd0);
    scenario_end("good");

    // bad checksum, then a good frame; error code holds afterwards
    add_byte(SYNC, 1); add_byte(8'h03, 1); add_byte(8'h11, 1);
    add_byte(8'h22, 1); add_byte(8'h33, 1); add_byte(8'h04, 3);
    add_byte(SYNC, 1); add_byte(8'h01, 1); add_byte(8'h7E, 1); add_byte(8'h7F, 24);
    model_stream();
    run_stream();
    check("badchk_code_held", 32'(err_code), 32'd2);
    scenario_end("badchk");

    // zero and oversize length, then hunting resumes
    add_byte(SYNC, 1); add_byte(8'h00, 2); add_byte(SYNC, 1); add_byte(8'h11, 2);
    add_byte(8'h3C, 1); add_byte(SYNC, 1); add_byte(8'h02, 1);
    add_byte(8'h55, 1); add_byte(8'h66, 1); add_byte(8'h31, 24);
    model_stream();
    run_stream();
    scenario_end("badlen");

    // timeout: error lands TO_CYC cycles after the last strobe
    send_byte(SYNC); idle(1); send_byte(8'h02); idle(1); send_byte(8'h11);
    k = 0;
    while (got_err_q.size() == 0 && k < TO_CYC + 20) begin
      step();
      k++;
    end
    check("timeout_latency", 32'(k), 32'(TO_CYC));
    exp_err_q.push_back(2'd3);
    idle(4);
    scenario_end("timeout");

    // byte arriving on the expiry cycle keeps the packet alive
    add_byte(SYNC, 1); add_byte(8'h02, 1); add_byte(8'h11, TO_CYC - 2);
    add_byte(8'h22, 1); add_byte(8'h31, 24);
    model_stream();
    run_stream();
    scenario_end("timeout_race");

    // backpressure on the second byte plus a byte dropped during drain
    add_byte(SYNC, 1); add_byte(8'h03, 1); add_byte(8'h11, 1);
    add_byte(8'h22, 1); add_byte(8'h33, 1); add_byte(8'h03, 0);
    model_stream();
    for (int i = 0; i < stim_q.size() - 1; i++) begin
      send_byte(stim_q[i]);
      idle(1);
    end
    send_byte(stim_q[stim_q.size()-1]);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_data", 32'(out_data), 32'h22);
      if (i == 2) begin
        rx_data = 8'($urandom);
        rx_done = 1'b1;
      end
      step();
      rx_done = 1'b0;
    end
    out_ready = 1'b1;
    idle(10);
    exp_ovr = 1;
    scenario_end("backpressure");

    // noise before a frame
    add_byte(8'h00, 2); add_byte(8'hFF, 2); add_byte(8'h5A, 2);
    add_byte(SYNC, 1); add_byte(8'h01, 1); add_byte(8'h7E, 1); add_byte(8'h7F, 24);
    model_stream();
    run_stream();
    scenario_end("noise");

    // enable dropped mid-packet: silent abort, then a clean frame
    send_byte(SYNC); idle(1); send_byte(8'h02); idle(1);
    enable = 1'b0;
    idle(2);
    enable = 1'b1;
    idle(TO_CYC + 10);
    add_byte(SYNC, 1); add_byte(8'h01, 1); add_byte(8'h7E, 1); add_byte(8'h7F, 24);
    model_stream();
    run_stream();
    scenario_end("enable");

    // reset asserted mid-payload, remnant bytes afterwards produce nothing
    send_byte(SYNC); idle(1); send_byte(8'h04); idle(1);
    send_byte(8'h11); idle(1); send_byte(8'h22);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    prev_hold = 1'b0;
    prev_last = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    add_byte(8'h33, 2); add_byte(8'h44, 2); add_byte(8'h04, 30);
    model_stream();
    run_stream();
    scenario_end("midreset");

    // random streams
    for (int r = 0; r < 4; r++) begin
      if (r == 0) begin
        add_frame(int'(MAX_LEN), 1'b0);
        add_frame(1, 1'b0);
      end
      repeat (6) begin
        case ($urandom_range(0, 4))
          0, 1: add_frame($urandom_range(1, MAX_LEN), 1'b0);
          2: add_frame($urandom_range(1, MAX_LEN), 1'b1);
          3: begin
            add_byte(SYNC, $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) add_byte(8'h00, $urandom_range(0, 3));
            else add_byte(8'($urandom_range(MAX_LEN + 1, 255)), $urandom_range(0, 3));
          end
          default: begin
            logic [7:0] p;
            p = 8'($urandom);
            while (p == SYNC) p = 8'($urandom);
            add_byte(p, $urandom_range(0, 3));
          end
        endcase
      end
      add_byte(8'h00, MAX_LEN + 4);
      model_stream();
      run_stream();
      scenario_end("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_pkt_rx_ctrl.md
Name: uart_pkt_rx_ctrl

Overview:
Packet-level controller placed directly after the byte-level UART receiver. It consumes the receiver's byte/strobe output and hunts for a sync byte. It then sequences length, payload and checksum fields, buffers the payload, and applies an inter-byte timeout. Only checksum-verified payloads are released to downstream logic, over a valid/ready byte stream.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 9600, UART bit rate; used only for the timeout calculation
SYNC_BYTE, 8'hA5, frame start marker
MAX_LEN, 16, maximum payload bytes (1..255); sets the buffer depth
TIMEOUT_BYTES, 4, allowed inter-byte gap in character times (10 bits each)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
enable  in  1  1 = accept packets; 0 = hunt disabled / abort current packet
rx_data  in  8  byte from the UART receiver
rx_done  in  1  single-cycle strobe; rx_data valid in that cycle
out_data  out  8  payload byte
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts the byte when out_valid && out_ready
out_last  out  1  high with the final payload byte
pkt_ok  out  1  one-cycle pulse: packet verified, drain begins
pkt_err  out  1  one-cycle pulse: packet rejected
err_code  out  2  0 none, 1 bad length, 2 checksum, 3 timeout; valid with pkt_err, held until the next pkt_err
overrun  out  1  one-cycle pulse: byte arrived during DRAIN and was dropped

Behaviour:
- Reset: all outputs 0; state IDLE; pointers, counters and checksum accumulator cleared. Async assert, sync release.
- Timeout constant: TO_CYC = TIMEOUT_BYTES*10*(CLK_FREQ/BAUD_RATE), a localparam. The counter is wide enough for TO_CYC.
- States and transitions:
  - IDLE: on rx_done with enable=1 and rx_data==SYNC_BYTE -> LEN. Any other byte is ignored silently.
  - LEN: on rx_done, if rx_data==0 or rx_data>MAX_LEN -> pkt_err with code 1, -> IDLE. Otherwise latch len, set chk=rx_data, wr_ptr=0, -> PAYLOAD.
  - PAYLOAD: on rx_done, buf[wr_ptr]=rx_data, chk^=rx_data, wr_ptr++. When wr_ptr reaches len -> CHK.
  - CHK: on rx_done, if rx_data==chk -> pkt_ok, rd_ptr=0, -> DRAIN. Otherwise pkt_err with code 2, -> IDLE.
  - DRAIN: out_valid=1, out_data=buf[rd_ptr], out_last=(rd_ptr==len-1). On a transfer, rd_ptr++. A transfer with out_last high -> IDLE, with out_valid low in the next cycle.
- pkt_ok and pkt_err assert in the cycle after the deciding rx_done (registered).
- Checksum: 8-bit XOR of the LEN byte and all payload bytes.
- Timeout applies in LEN, PAYLOAD and CHK only:
  - Counter clears on entry to those states and on every rx_done.
  - Reaching TO_CYC-1 -> pkt_err with code 3, -> IDLE.
  - If rx_done and expiry occur in the same cycle, rx_done wins and the counter clears.
- DRAIN:
  - rx_done is dropped and overrun is pulsed for that byte; the state does not change.
  - out_data, out_valid and out_last stay stable while out_valid && !out_ready.
- enable=0:
  - In LEN/PAYLOAD/CHK: next cycle -> IDLE, no pkt_err.
  - In DRAIN: the drain completes normally.
- A SYNC_BYTE value inside LEN/PAYLOAD/CHK is treated as data; there is no resynchronisation.
- Reset mid-packet or mid-drain: returns immediately to reset state. A partial packet is never output.

Decomposition:
- Shared header uart_pkt_defs: state encodings (IDLE, LEN, PAYLOAD, CHK, DRAIN), err_code constants, default SYNC_BYTE.
- One sub-module: uart_gap_timer.
  - Inputs: clk, rst, arm, kick.
  - Output: expire, a one-cycle pulse.
  - Parameter: TO_CYC.
- The payload buffer is an inline register array of MAX_LEN x 8.

Test Plan:
- Good frame: A5 03 11 22 33 03, out_ready=1 -> pkt_ok once; out bytes 11,22,33 on consecutive cycles; out_last with 33; err_code stays 0.
- Bad checksum: A5 03 11 22 33 04 -> pkt_err with err_code=2; out_valid never asserts; the next good frame is accepted.
- Bad length: A5 00 and A5 11 (with MAX_LEN=16) -> pkt_err with err_code=1 each time; the following bytes are hunted for A5.
- Timeout: A5 02 11 then idle -> pkt_err with err_code=3 exactly TO_CYC cycles after the 11 strobe. Second run: a byte arriving on the expiry cycle is accepted with no error.
- Backpressure and overrun: good 3-byte frame, out_ready low for 5 cycles after the first byte, plus one rx_done during DRAIN.
  - out_data held at 22 while out_ready is low.
  - overrun pulses once.
  - All 3 bytes are delivered.
- Noise, enable and reset: 00 FF 5A A5 01 7E 7F delivers 7E. enable dropped after A5 02 -> silent return to IDLE. rst asserted mid-PAYLOAD -> all outputs 0 immediately.
